accum_display: RTL and testbench



---
 rtl/accum_display_if.sv | 16 +
 rtl/accum_display.sv | 141 ++++++++++++++
 tb/tb_accum_display.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_display_if.sv
// Load/convert handshake and 7-segment display bundle between the accumulator
// sum register and accum_display.
interface accum_display_if #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    Value;
    logic                Load;
    logic                Busy;
    logic                Done;
    logic                Ovf;
    logic [7*DIGITS-1:0] Segs;

    modport master (output Value, Load, input Busy, Done, Ovf, Segs);
    modport slave  (input Value, Load, output Busy, Done, Ovf, Segs);
endinterface

// File: rtl/accum_display.sv
// Binary-to-decimal HEX display driver: sequential double-dabble (one shift per clock)
// feeding active-low 7-segment codes. Define ACCUM_DISPLAY_BLANK_LZ_EN to blank leading zeros.
module accum_display #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    accum_display_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int               BCD_W     = 4 * DIGITS;
    localparam logic [63:0]      MAX_VAL   = 64'(10**DIGITS - 1);
    localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);
    localparam logic [6:0]       SEG_DASH  = 7'b0111111;
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
    localparam logic [6:0]       SEG_BLANK = 7'b1111111;
`endif

    state_t             state, next_state;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   iter_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   disp_bcd;
    logic               ovf_pending;
    logic               ovf_q;
    logic               done_q;
    logic [7*DIGITS-1:0] segs_c;
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
    logic               leading;
`endif

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.Load) next_state = SHIFT;
            SHIFT:   if (iter_q == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Double-dabble correction applied to the digits before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shift_q     <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            disp_bcd    <= '0;
            ovf_pending <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Load) begin
                        shift_q     <= bus.Value;
                        bcd_q       <= '0;
                        iter_q      <= '0;
                        ovf_pending <= 64'(bus.Value) > MAX_VAL;
                    end
                end
                SHIFT: begin
                    // Bits leaving the top digit are dropped; Ovf covers them.
                    bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                    shift_q <= shift_q << 1;
                    iter_q  <= iter_q + WIDTH'(1);
                end
                DONE: begin
                    disp_bcd <= bcd_q;
                    ovf_q    <= ovf_pending;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Display decode reads only registers updated at DONE, so Segs cannot glitch mid-conversion.
    always_comb begin
        segs_c = '0;
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
        leading = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_q) begin
                segs_c[7*i +: 7] = SEG_DASH;
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
            end else if (leading && i != 0 && disp_bcd[4*i +: 4] == 4'd0) begin
                segs_c[7*i +: 7] = SEG_BLANK;
`endif
            end else begin
                segs_c[7*i +: 7] = seg_code(disp_bcd[4*i +: 4]);
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
                leading = 1'b0;
`endif
            end
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.Ovf  = ovf_q;
    assign bus.Segs = segs_c;

endmodule

// File: tb/tb_accum_display.sv
// Self-checking bench for accum_display: a 4-digit and a 3-digit instance share one
// Load/Value stream; a scoreboard checks every Done against an arithmetic decimal model.
module tb_accum_display;
    localparam int W = 10;
`ifdef ACCUM_DISPLAY_BLANK_LZ_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [27:0] segs;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] value;
        logic         ovf3;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] value;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done4 = 0;
    exp_t sb4[$];
    exp_t sb3[$];
    exp_t e4, e3;

    always #5 clk = ~clk;

    accum_display_if #(.WIDTH(W), .DIGITS(4)) bus4 ();
    accum_display_if #(.WIDTH(W), .DIGITS(3)) bus3 ();

    assign bus4.Load  = load;
    assign bus4.Value = value;
    assign bus3.Load  = load;
    assign bus3.Value = value;

    accum_display #(.WIDTH(W), .DIGITS(4)) dut4 (.Clock(clk), .Reset(rst), .bus(bus4));
    accum_display #(.WIDTH(W), .DIGITS(3)) dut3 (.Clock(clk), .Reset(rst), .bus(bus3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Reference display built from integer division, not from a BCD shifter.
    function automatic logic [27:0] model_segs(input int v, input int nd);
        logic [27:0] r;
        int          p;
        int          lim;
        r   = '0;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (v >= lim)                    r[7*i +: 7] = 7'b0111111;
            else if (BLANK && i > 0 && v < p) r[7*i +: 7] = 7'b1111111;
            else                             r[7*i +: 7] = digit_code((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic push(input logic [W-1:0] v);
        exp_t e;
        e.segs = model_segs(int'(v), 4);
        e.ovf  = (int'(v) > 9999);
        sb4.push_back(e);
        e.segs = model_segs(int'(v), 3);
        e.ovf  = (int'(v) > 999);
        sb3.push_back(e);
    endtask

    always @(negedge clk) begin
        if (bus4.Done === 1'b1) begin
            done4++;
            if (sb4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done4_spurious: got Done=1, expected no pending conversion at %0t", $time);
            end else begin
                e4 = sb4.pop_front();
                check("segs4", 64'(bus4.Segs), 64'(e4.segs));
                check("ovf4", 64'(bus4.Ovf), 64'(e4.ovf));
            end
        end
        if (bus3.Done === 1'b1) begin
            if (sb3.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done3_spurious: got Done=1, expected no pending conversion at %0t", $time);
            end else begin
                e3 = sb3.pop_front();
                check("segs3", 64'(bus3.Segs), 64'(e3.segs));
                check("ovf3", 64'(bus3.Ovf), 64'(e3.ovf));
            end
        end
    end

    // Drive one Load at the current point (a negedge), track Busy/Segs until Done.
    // glitch >= 0 pulses Load with Value=5 that many edges after acceptance.
    task automatic run_conv(input logic [W-1:0] v, input int glitch, input string tag);
        int          lat;
        bit          done_seen;
        bit          busy_ok;
        bit          hold_ok;
        logic [27:0] held4;
        held4 = bus4.Segs;
        value = v;
        load  = 1'b1;
        push(v);
        @(posedge clk);
        #1;
        load  = 1'b0;
        value = W'($urandom);
        lat = 0;
        done_seen = 1'b0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!done_seen && lat < 40) begin
            @(negedge clk);
            if (bus4.Done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (bus4.Busy !== 1'b1) busy_ok = 1'b0;
                if (bus4.Segs !== held4) hold_ok = 1'b0;
                if (lat == glitch) begin
                    load  = 1'b1;
                    value = W'(5);
                end
            end
            if (!done_seen) begin
                @(posedge clk);
                #1;
                load  = 1'b0;
                value = W'($urandom);
                lat++;
            end
        end
        #1;
        check({tag, "_latency"}, 64'(lat), 64'(11));
        check({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
        check({tag, "_segs_held"}, 64'(hold_ok), 64'(1));
        check({tag, "_busy_clear"}, 64'(bus4.Busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        int   d0;
        tbl = '{
            '{value: 10'd0,    ovf3: 1'b0},
            '{value: 10'd1,    ovf3: 1'b0},
            '{value: 10'd9,    ovf3: 1'b0},
            '{value: 10'd10,   ovf3: 1'b0},
            '{value: 10'd99,   ovf3: 1'b0},
            '{value: 10'd100,  ovf3: 1'b0},
            '{value: 10'd512,  ovf3: 1'b0},
            '{value: 10'd640,  ovf3: 1'b0},
            '{value: 10'd999,  ovf3: 1'b0},
            '{value: 10'd1000, ovf3: 1'b1},
            '{value: 10'd1001, ovf3: 1'b1},
            '{value: 10'd1023, ovf3: 1'b1},
            '{value: 10'd305,  ovf3: 1'b0}
        };

        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(bus4.Busy), 64'(0));
        check("reset_done", 64'(bus4.Done), 64'(0));
        check("reset_ovf", 64'(bus4.Ovf), 64'(0));
        check("reset_hex0", 64'(bus4.Segs[6:0]), 64'(7'b1000000));
        check("reset_hex_upper", 64'(bus4.Segs[27:7]),
              BLANK ? 64'({3{7'b1111111}}) : 64'({3{7'b1000000}}));
        check("reset_segs3", 64'(bus3.Segs), 64'(model_segs(0, 3)));

        // 1023 with an ignored Load on the edge where the FSM sits in DONE.
        d0 = done4;
        run_conv(10'd1023, 10, "v1023");
        check("hex_1023", 64'(bus4.Segs),
              64'({7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000}));
        check("ovf_1023", 64'(bus4.Ovf), 64'(0));
        check("done_count_1023", 64'(done4 - d0), 64'(1));

        // Load on the edge immediately after Done must be accepted.
        run_conv(10'd5, -1, "v5_b2b");
        check("done_count_b2b", 64'(done4 - d0), 64'(2));
        check("hex_5", 64'(bus4.Segs[6:0]), 64'(7'b0010010));

        // Load ignored early in SHIFT too.
        run_conv(10'd7, 0, "v7");
        check("hex_7", 64'(bus4.Segs[6:0]), 64'(7'b1111000));
        check("hex_7_upper", 64'(bus4.Segs[27:7]),
              BLANK ? 64'({3{7'b1111111}}) : 64'({3{7'b1000000}}));

        run_conv(10'd1000, -1, "v1000");
        check("ovf3_1000", 64'(bus3.Ovf), 64'(1));
        check("dash3_1000", 64'(bus3.Segs), 64'({3{7'b0111111}}));
        run_conv(10'd999, -1, "v999");
        check("ovf3_999", 64'(bus3.Ovf), 64'(0));
        check("hex3_999", 64'(bus3.Segs), 64'({3{7'b0010000}}));

        for (int i = 0; i < 13; i++) begin
            run_conv(tbl[i].value, -1, "tbl");
            check("tbl_ovf3", 64'(bus3.Ovf), 64'(tbl[i].ovf3));
        end

        // Reset during the 5th SHIFT cycle discards the conversion.
        @(negedge clk);
        value = 10'd512;
        load  = 1'b1;
        push(10'd512);
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus4.Busy), 64'(0));
        check("abort_done", 64'(bus4.Done), 64'(0));
        check("abort_ovf3", 64'(bus3.Ovf), 64'(0));
        check("abort_segs4", 64'(bus4.Segs), 64'(model_segs(0, 4)));
        check("abort_segs3", 64'(bus3.Segs), 64'(model_segs(0, 3)));
        sb4.delete();
        sb3.delete();
        d0 = done4;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 64'(done4 - d0), 64'(0));
        run_conv(10'd512, -1, "v512_after_rst");
        check("hex_512", 64'(bus4.Segs[20:0]),
              64'({7'b0010010, 7'b1111001, 7'b0100100}));
        check("done_count_512", 64'(done4 - d0), 64'(1));

        repeat (3) @(negedge clk);
        check("sb4_drained", 64'(sb4.size()), 64'(0));
        check("sb3_drained", 64'(sb3.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
